// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between the fetch stage
// and the memory stage. One transaction is in flight at a time. Data accesses
// win arbitration, but a starvation counter keeps fetch moving. A timeout
// counter aborts a transaction whose bus_ack never arrives.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,

  // fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_valid,
  output logic [31:0] if_rdata,

  // data requester
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_size,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,

  // pipeline stalls
  output logic        stallF,
  output logic        stallM,

  // unified memory bus
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [2:0]  bus_size,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_timeout
);

  // Fetch is always a plain word read.
  localparam logic [2:0] FETCH_SIZE = 3'b010;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [9:0]  tmo_cnt_q, tmo_cnt_d;
  logic        discard_q, discard_d;

  logic        if_valid_q, if_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        dm_valid_q, dm_valid_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [2:0]  bus_size_q, bus_size_d;
  logic        bus_timeout_q, bus_timeout_d;

  logic        if_elig;
  logic        dm_elig;
  logic        grant_data;
  logic        grant_fetch;
  logic        finish_txn;

  // A flush in the DONE cycle must still hide the already-registered pulse,
  // so the fetch valid is gated by the live flush input.
  assign if_valid = if_valid_q & ~if_flush;
  assign if_rdata = if_rdata_q;
  assign dm_valid = dm_valid_q;
  assign dm_rdata = dm_rdata_q;

  assign stallF = if_req & ~if_valid;
  assign stallM = dm_req & ~dm_valid_q;

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_size    = bus_size_q;
  assign bus_timeout = bus_timeout_q;

  // A requester whose valid is showing this cycle is not eligible, so the
  // same request can never be granted twice.
  assign if_elig     = if_req & ~if_valid;
  assign dm_elig     = dm_req & ~dm_valid_q;
  assign grant_data  = dm_elig & (~if_elig | (starve_cnt_q < STARVE_LIM));
  assign grant_fetch = if_elig & ~grant_data;

  // A transaction ends on ack, or on the last allowed cycle without ack.
  assign finish_txn  = bus_ack | (tmo_cnt_q == TMO_LAST);

  // Next-state logic: arbitration in IDLE, ack/timeout handling while the
  // bus is owned, and a single DONE cycle that presents the owner's valid.
  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    discard_d     = discard_q;
    if_valid_d    = 1'b0;
    if_rdata_d    = if_rdata_q;
    dm_valid_d    = 1'b0;
    dm_rdata_d    = dm_rdata_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_size_d    = bus_size_q;
    bus_timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d     = DATA;
          bus_req_d   = 1'b1;
          bus_we_d    = dm_we;
          bus_addr_d  = dm_addr;
          bus_wdata_d = dm_wdata;
          bus_size_d  = dm_size;
          tmo_cnt_d   = '0;
          discard_d   = 1'b0;
          if (!if_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (grant_fetch) begin
          state_d      = FETCH;
          bus_req_d    = 1'b1;
          bus_we_d     = 1'b0;
          bus_addr_d   = if_addr;
          bus_wdata_d  = '0;
          bus_size_d   = FETCH_SIZE;
          tmo_cnt_d    = '0;
          discard_d    = 1'b0;
          starve_cnt_d = '0;
        end
      end

      FETCH: begin
        if (if_flush) begin
          discard_d = 1'b1;
        end
        if (finish_txn) begin
          state_d       = DONE;
          bus_req_d     = 1'b0;
          bus_timeout_d = ~bus_ack;
          if_rdata_d    = bus_ack ? bus_rdata : 32'h0;
          if_valid_d    = ~(discard_q | if_flush);
        end else begin
          tmo_cnt_d = tmo_cnt_q + 10'd1;
        end
      end

      DATA: begin
        if (finish_txn) begin
          state_d       = DONE;
          bus_req_d     = 1'b0;
          bus_timeout_d = ~bus_ack;
          dm_rdata_d    = (bus_ack && !bus_we_q) ? bus_rdata : 32'h0;
          dm_valid_d    = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 10'd1;
        end
      end

      DONE: begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops bus_req immediately and
  // forgets any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      starve_cnt_q  <= '0;
      tmo_cnt_q     <= '0;
      discard_q     <= 1'b0;
      if_valid_q    <= 1'b0;
      if_rdata_q    <= '0;
      dm_valid_q    <= 1'b0;
      dm_rdata_q    <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_size_q    <= '0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      discard_q     <= discard_d;
      if_valid_q    <= if_valid_d;
      if_rdata_q    <= if_rdata_d;
      dm_valid_q    <= dm_valid_d;
      dm_rdata_q    <= dm_rdata_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_size_q    <= bus_size_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter. Stimulus pushes
// the expected bus transactions and responses; a forked monitor compares them
// as the DUT raises bus_req and the valid pulses. A forked responder models
// the memory, acking after a programmable number of bus_req cycles and
// returning {addr[15:0], 16'hC0DE} as read data.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [2:0]  dm_size;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        stallF, stallM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [2:0]  bus_size;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_timeout;

  logic        resp_ack, manual_ack;
  int          ack_delay;
  int          cyc = 0;
  int          errors, checks;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    int          gap;
  } bus_exp_t;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
    bit          tmo;
    int          lat;
  } resp_exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
  } dm_op_t;

  bus_exp_t    exp_bus[$];
  resp_exp_t   exp_resp[$];
  dm_op_t      dm_ops[$];
  logic [31:0] if_ops[$];

  bus_exp_t    mon_b;
  resp_exp_t   mon_r;
  bit          mon_prev_req;
  int          mon_rise_cyc;
  int          mon_last_valid;
  bit          rsp_in_txn;
  int          rsp_wait;

  assign bus_ack = resp_ack | manual_ack;

  mem_port_arbiter #(
    .STARVE_MAX(4),
    .TIMEOUT   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_valid   (if_valid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_size    (dm_size),
    .dm_valid   (dm_valid),
    .dm_rdata   (dm_rdata),
    .stallF     (stallF),
    .stallM     (stallM),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_size   (bus_size),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .bus_timeout(bus_timeout)
  );

  // Free-running 10 ns clock.
  initial forever #5 clk = ~clk;

  // Cycle counter used for latency and grant-spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something wedges the main sequence.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got time %0t required < 500000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expectBus(input bit is_data, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] size, input int gap);
    bus_exp_t e;
    e.is_data = is_data;
    e.we      = we;
    e.addr    = addr;
    e.wdata   = wdata;
    e.size    = size;
    e.gap     = gap;
    exp_bus.push_back(e);
  endtask

  task automatic expectResp(input bit is_data, input logic [31:0] rdata, input bit tmo, input int lat);
    resp_exp_t r;
    r.is_data = is_data;
    r.rdata   = rdata;
    r.tmo     = tmo;
    r.lat     = lat;
    exp_resp.push_back(r);
  endtask

  // Presents the heads of the fetch and data op queues as live requests.
  task automatic applyStimulus();
    if_req = (if_ops.size() > 0);
    if_addr = (if_ops.size() > 0) ? if_ops[0] : 32'h0;
    dm_req = (dm_ops.size() > 0);
    if (dm_ops.size() > 0) begin
      dm_we    = dm_ops[0].we;
      dm_addr  = dm_ops[0].addr;
      dm_wdata = dm_ops[0].wdata;
      dm_size  = dm_ops[0].size;
    end else begin
      dm_we    = 1'b0;
      dm_addr  = 32'h0;
      dm_wdata = 32'h0;
      dm_size  = 3'b000;
    end
  endtask

  // Behaves like both pipeline stages: holds each request until its valid,
  // then moves to the next op in the following cycle.
  task automatic serve(input int budget);
    bit dv, iv;
    int c;
    @(posedge clk); #1;
    applyStimulus();
    c = 0;
    while ((if_ops.size() > 0 || dm_ops.size() > 0) && c < budget) begin
      @(negedge clk);
      dv = dm_valid;
      iv = if_valid;
      @(posedge clk); #1;
      if (dv && dm_ops.size() > 0) void'(dm_ops.pop_front());
      if (iv && if_ops.size() > 0) void'(if_ops.pop_front());
      applyStimulus();
      c++;
    end
    checkOutput("serve_ops_left", 32'(if_ops.size() + dm_ops.size()), 32'h0);
    if_ops.delete();
    dm_ops.delete();
    applyStimulus();
  endtask

  task automatic pushLoad(input logic [31:0] addr, input logic [2:0] size);
    dm_op_t o;
    o.we = 1'b0; o.addr = addr; o.wdata = 32'h0; o.size = size;
    dm_ops.push_back(o);
  endtask

  task automatic pushStore(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] size);
    dm_op_t o;
    o.we = 1'b1; o.addr = addr; o.wdata = wdata; o.size = size;
    dm_ops.push_back(o);
  endtask

  initial begin
    bit got;
    errors = 0; checks = 0;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_size = '0;
    resp_ack = 1'b0; manual_ack = 1'b0; bus_rdata = '0;
    ack_delay = 0;
    mon_prev_req = 1'b0; mon_rise_cyc = 0; mon_last_valid = -100;
    rsp_in_txn = 1'b0; rsp_wait = 0;

    fork
      // Monitor: compares each bus_req rise and each valid pulse against the
      // scoreboard queues.
      forever begin
        @(negedge clk);
        if (rst) begin
          mon_prev_req = 1'b0;
        end else begin
          if (bus_req && !mon_prev_req) begin
            mon_rise_cyc = cyc;
            if (exp_bus.size() == 0) begin
              checkOutput("bus_req_unexpected", 32'(bus_req), 32'h0);
            end else begin
              mon_b = exp_bus.pop_front();
              checkOutput("bus_we", 32'(bus_we), 32'(mon_b.we));
              checkOutput("bus_addr", bus_addr, mon_b.addr);
              if (mon_b.is_data) begin
                checkOutput("bus_wdata", bus_wdata, mon_b.wdata);
                checkOutput("bus_size", 32'(bus_size), 32'(mon_b.size));
              end
              if (mon_b.gap >= 0)
                checkOutput("grant_after_valid", 32'(mon_rise_cyc - mon_last_valid), 32'(mon_b.gap));
            end
          end
          mon_prev_req = bus_req;
          if (if_valid || dm_valid) begin
            mon_last_valid = cyc;
            if (exp_resp.size() == 0) begin
              checkOutput("valid_unexpected", 32'({if_valid, dm_valid}), 32'h0);
            end else begin
              mon_r = exp_resp.pop_front();
              checkOutput("valid_owner", 32'({if_valid, dm_valid}), mon_r.is_data ? 32'h1 : 32'h2);
              checkOutput("rdata", mon_r.is_data ? dm_rdata : if_rdata, mon_r.rdata);
              checkOutput("bus_timeout", 32'(bus_timeout), 32'(mon_r.tmo));
              checkOutput("latency", 32'(cyc - mon_rise_cyc), 32'(mon_r.lat));
            end
          end else if (bus_timeout) begin
            checkOutput("bus_timeout_orphan", 32'(bus_timeout), 32'h0);
          end
        end
      end
      // Memory responder: acks after ack_delay cycles of bus_req.
      forever begin
        @(negedge clk);
        resp_ack = 1'b0;
        if (rst || !bus_req) begin
          rsp_in_txn = 1'b0;
        end else begin
          if (!rsp_in_txn) begin
            rsp_in_txn = 1'b1;
            rsp_wait = 0;
          end
          if (rsp_wait == ack_delay) begin
            resp_ack   = 1'b1;
            bus_rdata  = {bus_addr[15:0], 16'hC0DE};
            rsp_in_txn = 1'b0;
          end else begin
            rsp_wait++;
          end
        end
      end
    join_none

    // Reset state: every output low.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_bus_req", 32'(bus_req), 32'h0);
    checkOutput("rst_bus_we", 32'(bus_we), 32'h0);
    checkOutput("rst_bus_addr", bus_addr, 32'h0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
    checkOutput("rst_bus_size", 32'(bus_size), 32'h0);
    checkOutput("rst_bus_timeout", 32'(bus_timeout), 32'h0);
    checkOutput("rst_if_valid", 32'(if_valid), 32'h0);
    checkOutput("rst_if_rdata", if_rdata, 32'h0);
    checkOutput("rst_dm_valid", 32'(dm_valid), 32'h0);
    checkOutput("rst_dm_rdata", dm_rdata, 32'h0);
    checkOutput("rst_stalls", 32'({stallF, stallM}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fetch only, minimum latency: valid at grant+2.
    $display("[TB] fetch only");
    ack_delay = 0;
    if_ops.push_back(32'h0000_0100);
    expectBus(1'b0, 1'b0, 32'h0000_0100, 32'h0, 3'b000, -1);
    expectResp(1'b0, 32'h0100_C0DE, 1'b0, 1);
    serve(20);

    // Simultaneous data and fetch: data first, fetch right after dm_valid.
    $display("[TB] simultaneous requests");
    pushLoad(32'h0000_2000, 3'b100);
    if_ops.push_back(32'h0000_0104);
    expectBus(1'b1, 1'b0, 32'h0000_2000, 32'h0, 3'b100, -1);
    expectResp(1'b1, 32'h2000_C0DE, 1'b0, 1);
    expectBus(1'b0, 1'b0, 32'h0000_0104, 32'h0, 3'b000, 2);
    expectResp(1'b0, 32'h0104_C0DE, 1'b0, 1);
    serve(30);

    // Starvation limit 4: grant order D,D,D,D,F,D.
    $display("[TB] starvation");
    pushLoad(32'h0000_3000, 3'b010);
    pushLoad(32'h0000_3004, 3'b010);
    pushLoad(32'h0000_3008, 3'b010);
    pushLoad(32'h0000_300C, 3'b010);
    pushLoad(32'h0000_3010, 3'b010);
    if_ops.push_back(32'h0000_0108);
    expectBus(1'b1, 1'b0, 32'h0000_3000, 32'h0, 3'b010, -1);
    expectResp(1'b1, 32'h3000_C0DE, 1'b0, 1);
    expectBus(1'b1, 1'b0, 32'h0000_3004, 32'h0, 3'b010, 2);
    expectResp(1'b1, 32'h3004_C0DE, 1'b0, 1);
    expectBus(1'b1, 1'b0, 32'h0000_3008, 32'h0, 3'b010, 2);
    expectResp(1'b1, 32'h3008_C0DE, 1'b0, 1);
    expectBus(1'b1, 1'b0, 32'h0000_300C, 32'h0, 3'b010, 2);
    expectResp(1'b1, 32'h300C_C0DE, 1'b0, 1);
    expectBus(1'b0, 1'b0, 32'h0000_0108, 32'h0, 3'b000, 2);
    expectResp(1'b0, 32'h0108_C0DE, 1'b0, 1);
    expectBus(1'b1, 1'b0, 32'h0000_3010, 32'h0, 3'b010, 2);
    expectResp(1'b1, 32'h3010_C0DE, 1'b0, 1);
    serve(60);

    // Flush one cycle after grant; ack 3 cycles later; refetch 0x200.
    $display("[TB] flush during fetch");
    ack_delay = 3;
    expectBus(1'b0, 1'b0, 32'h0000_010C, 32'h0, 3'b000, -1);
    expectBus(1'b0, 1'b0, 32'h0000_0200, 32'h0, 3'b000, -1);
    expectResp(1'b0, 32'h0200_C0DE, 1'b0, 4);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_010C;
    @(negedge clk);
    checkOutput("stallF_pending", 32'(stallF), 32'h1);
    @(posedge clk); #1;
    if_flush = 1'b1;
    @(posedge clk); #1;
    if_flush = 1'b0; if_addr = 32'h0000_0200;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      got = if_valid;
    end
    checkOutput("refetch_returned", 32'(got), 32'h1);
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = 32'h0;

    // Flush landing in the DONE cycle hides the pulse.
    $display("[TB] flush in done cycle");
    ack_delay = 0;
    expectBus(1'b0, 1'b0, 32'h0000_0110, 32'h0, 3'b000, -1);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0110;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if_flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    checkOutput("if_valid_flushed_in_done", 32'(if_valid), 32'h0);
    @(posedge clk); #1;
    if_flush = 1'b0; if_addr = 32'h0;
    repeat (3) @(negedge clk);

    // Store with no ack: abort after TIMEOUT=8 bus_req cycles.
    $display("[TB] store timeout");
    ack_delay = 1000;
    pushStore(32'h0000_4000, 32'hDEAD_BEEF, 3'b010);
    expectBus(1'b1, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 3'b010, -1);
    expectResp(1'b1, 32'h0, 1'b1, 8);
    serve(30);
    @(negedge clk);
    checkOutput("bus_req_after_abort", 32'(bus_req), 32'h0);

    // Acked store returns rdata 0.
    $display("[TB] store acked");
    ack_delay = 1;
    pushStore(32'h0000_4004, 32'h1234_5678, 3'b001);
    expectBus(1'b1, 1'b1, 32'h0000_4004, 32'h1234_5678, 3'b001, -1);
    expectResp(1'b1, 32'h0, 1'b0, 2);
    serve(20);

    // Reset mid-transaction, then a stale ack after release.
    $display("[TB] reset mid-transaction");
    ack_delay = 1000;
    expectBus(1'b0, 1'b0, 32'h0000_0300, 32'h0, 3'b000, -1);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0300;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      got = bus_req;
    end
    checkOutput("bus_req_before_reset", 32'(got), 32'h1);
    #2;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    #1;
    checkOutput("midrst_bus_req", 32'(bus_req), 32'h0);
    checkOutput("midrst_valids", 32'({if_valid, dm_valid}), 32'h0);
    checkOutput("midrst_bus_timeout", 32'(bus_timeout), 32'h0);
    checkOutput("midrst_bus_addr", bus_addr, 32'h0);
    checkOutput("midrst_stalls", 32'({stallF, stallM}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    manual_ack = 1'b1;
    @(posedge clk); #1;
    manual_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("post_reset_bus_req", 32'(bus_req), 32'h0);
      checkOutput("post_reset_valids", 32'({if_valid, dm_valid, bus_timeout}), 32'h0);
    end

    // Requester re-requests after reset.
    $display("[TB] re-request after reset");
    ack_delay = 0;
    if_ops.push_back(32'h0000_0300);
    expectBus(1'b0, 1'b0, 32'h0000_0300, 32'h0, 3'b000, -1);
    expectResp(1'b0, 32'h0300_C0DE, 1'b0, 1);
    serve(20);
    repeat (3) @(negedge clk);

    checkOutput("bus_queue_drained", 32'(exp_bus.size()), 32'h0);
    checkOutput("resp_queue_drained", 32'(exp_resp.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
